// File: rtl/mips_avl_arbiter.sv
// mips_avl_arbiter: shares one Avalon-MM slave between the CPU's
// instruction-fetch port (i_*) and data port (d_*), round-robin on ties.
//
// Ports:
//   clk, reset                      clock, async active-high reset
//   i_req/i_write/i_address/
//   i_byteenable/i_writedata        instruction port command
//   i_readdata, i_done              instruction port response
//   d_req/d_write/d_address/
//   d_byteenable/d_writedata        data port command
//   d_readdata, d_done              data port response
//   address/read/write/
//   byteenable/writedata            Avalon master command
//   readdata, waitrequest           Avalon slave response
//   grant, busy, timeout            status (grant: 0 = I, 1 = D)
module mips_avl_arbiter #(
    parameter int WAIT_LIMIT = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_req,
    input  logic        i_write,
    input  logic [31:0] i_address,
    input  logic [3:0]  i_byteenable,
    input  logic [31:0] i_writedata,
    output logic [31:0] i_readdata,
    output logic        i_done,
    input  logic        d_req,
    input  logic        d_write,
    input  logic [31:0] d_address,
    input  logic [3:0]  d_byteenable,
    input  logic [31:0] d_writedata,
    output logic [31:0] d_readdata,
    output logic        d_done,
    output logic [31:0] address,
    output logic        read,
    output logic        write,
    output logic [3:0]  byteenable,
    output logic [31:0] writedata,
    input  logic [31:0] readdata,
    input  logic        waitrequest,
    output logic        grant,
    output logic        busy,
    output logic        timeout
);

    localparam int CW = (WAIT_LIMIT > 0) ? $clog2(WAIT_LIMIT + 1) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUS  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic            r_last;
    logic            r_grant;
    logic            r_wr;
    logic [31:0]     r_addr;
    logic [3:0]      r_be;
    logic [31:0]     r_wd;
    logic [31:0]     r_ird;
    logic [31:0]     r_drd;
    logic            r_to;
    logic [CW-1:0]   r_cnt;

    logic            w_any;
    logic            w_pick;
    logic            w_wait_exp;

    // On a tie the port that did not win last time gets the bus.
    assign w_any  = i_req | d_req;
    assign w_pick = (i_req & d_req) ? ~r_last : d_req;

    // The limit is reached on the WAIT_LIMIT-th stalled cycle.
    assign w_wait_exp = (WAIT_LIMIT > 0) &&
                        (r_cnt == CW'(WAIT_LIMIT - 1));

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_any)
                    w_next = S_BUS;
            end
            S_BUS: begin
                if (!waitrequest || w_wait_exp)
                    w_next = S_DONE;
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_last  <= 1'b1;
            r_grant <= 1'b0;
            r_wr    <= 1'b0;
            r_addr  <= '0;
            r_be    <= '0;
            r_wd    <= '0;
            r_ird   <= '0;
            r_drd   <= '0;
            r_to    <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            r_to    <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_grant <= w_pick;
                        r_last  <= w_pick;
                        r_cnt   <= '0;
                        r_wr    <= w_pick ? d_write      : i_write;
                        r_addr  <= w_pick ? d_address    : i_address;
                        r_be    <= w_pick ? d_byteenable : i_byteenable;
                        r_wd    <= w_pick ? d_writedata  : i_writedata;
                    end
                end
                S_BUS: begin
                    if (!waitrequest) begin
                        if (!r_wr) begin
                            if (r_grant)
                                r_drd <= readdata;
                            else
                                r_ird <= readdata;
                        end
                    end else if (w_wait_exp) begin
                        r_to <= 1'b1;
                    end else if (WAIT_LIMIT > 0) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs decode registered state only; nothing passes straight
    // through from the slave side.
    assign read       = (r_state == S_BUS) && !r_wr;
    assign write      = (r_state == S_BUS) &&  r_wr;
    assign address    = r_addr;
    assign byteenable = r_be;
    assign writedata  = r_wd;
    assign busy       = (r_state != S_IDLE);
    assign grant      = r_grant;
    assign i_done     = (r_state == S_DONE) && !r_grant;
    assign d_done     = (r_state == S_DONE) &&  r_grant;
    assign i_readdata = r_ird;
    assign d_readdata = r_drd;
    assign timeout    = r_to;

endmodule
